// File: rtl/id_scoreboard_pkg.sv
// Shared definitions for the long-latency destination scoreboard:
// register-file address width, width defaults and drain FSM encoding.
package id_scoreboard_pkg;

  localparam int NCPU_REG_AW = 5;

  localparam int SB_P_ISSUE_WIDTH_DFLT = 1;
  localparam int SB_MAX_INFLIGHT_DFLT  = 4;
  localparam int SB_P_CNT_DFLT         = 3;

  typedef enum logic {
    SB_IDLE  = 1'b0,
    SB_DRAIN = 1'b1
  } sb_state_e;

endpackage

// File: rtl/popcnt.sv
// Population count of a DW-bit vector; result is P_DW+1 bits wide
// so that an all-ones input of width 1<<P_DW is representable.
module popcnt #(
  parameter int DW   = 2,
  parameter int P_DW = 1
) (
  input  logic [DW-1:0] bitmap,
  output logic [P_DW:0] count
);

  localparam int CW = P_DW + 1;

  always_comb begin
    count = '0;
    for (int i = 0; i < DW; i++) begin
      count = count + CW'(bitmap[i]);
    end
  end

endmodule

// File: rtl/id_scoreboard.sv
// Busy-bit scoreboard for in-flight long-latency destinations, with
// per-lane issue hazards and a post-flush drain sequencer.
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int CONFIG_P_ISSUE_WIDTH   = SB_P_ISSUE_WIDTH_DFLT,
  parameter int CONFIG_SB_MAX_INFLIGHT = SB_MAX_INFLIGHT_DFLT,
  parameter int CONFIG_SB_P_CNT        = SB_P_CNT_DFLT,
  parameter int IW                     = 1 << CONFIG_P_ISSUE_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          stall,
  input  logic [IW-1:0]                 id_valid,
  input  logic [IW-1:0]                 id_long,
  input  logic [IW-1:0]                 id_rf_we,
  input  logic [NCPU_REG_AW*IW-1:0]     id_rf_waddr,
  input  logic [IW-1:0]                 id_rs1_re,
  input  logic [IW-1:0]                 id_rs2_re,
  input  logic [NCPU_REG_AW*IW-1:0]     id_rs1_addr,
  input  logic [NCPU_REG_AW*IW-1:0]     id_rs2_addr,
  input  logic                          wb_valid,
  input  logic [NCPU_REG_AW-1:0]        wb_addr,
  output logic [IW-1:0]                 hzd,
  output logic                          sb_stall,
  output logic [CONFIG_SB_P_CNT-1:0]    inflight_cnt
);

  localparam int AW   = NCPU_REG_AW;
  localparam int NREG = 1 << AW;
  localparam int CW   = CONFIG_SB_P_CNT;
  localparam int PW   = CONFIG_P_ISSUE_WIDTH;

  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  sb_state_e       state_q, state_d;

  logic [IW-1:0]   acc;
  logic [PW:0]     acc_cnt;
  logic            dec;

  // Hazards: against committed busy state, plus older lanes in the same issue group
  always_comb begin
    logic [AW-1:0] wj, wk, r1k, r2k;
    hzd = '0;
    for (int k = 0; k < IW; k++) begin
      wk  = id_rf_waddr[k*AW +: AW];
      r1k = id_rs1_addr[k*AW +: AW];
      r2k = id_rs2_addr[k*AW +: AW];
      if ((id_rs1_re[k] && busy_q[r1k]) ||
          (id_rs2_re[k] && busy_q[r2k]) ||
          (id_rf_we[k]  && busy_q[wk])) begin
        hzd[k] = 1'b1;
      end
      for (int j = 0; j < k; j++) begin
        wj = id_rf_waddr[j*AW +: AW];
        if (id_long[j] && id_rf_we[j] && (wj != '0) &&
            ((id_rs1_re[k] && (r1k == wj)) ||
             (id_rs2_re[k] && (r2k == wj)) ||
             (id_rf_we[k]  && (wk  == wj)))) begin
          hzd[k] = 1'b1;
        end
      end
    end
  end

  assign acc = id_valid & id_long & id_rf_we &
               {IW{~stall & ~flush & (state_q == SB_IDLE)}};

  popcnt #(
    .DW   (IW),
    .P_DW (PW)
  ) u_popcnt (
    .bitmap (acc),
    .count  (acc_cnt)
  );

  // A stray writeback with nothing outstanding must not wrap the counter
  assign dec   = wb_valid & (cnt_q != '0);
  assign cnt_d = cnt_q + CW'(acc_cnt) - CW'(dec);

  // Clear before set so a same-cycle reissue of the written-back register stays busy
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) begin
      busy_d[wb_addr] = 1'b0;
    end
    for (int k = 0; k < IW; k++) begin
      if (acc[k] && (id_rf_waddr[k*AW +: AW] != '0)) begin
        busy_d[id_rf_waddr[k*AW +: AW]] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      cnt_q   <= '0;
      state_q <= SB_IDLE;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_IDLE:  if (flush && (cnt_d != '0)) state_d = SB_DRAIN;
      SB_DRAIN: if (cnt_d == '0)            state_d = SB_IDLE;
      default:                              state_d = SB_IDLE;
    endcase
  end

  always_comb begin
    sb_stall     = (state_q == SB_DRAIN) ||
                   (cnt_q > CW'(CONFIG_SB_MAX_INFLIGHT - IW));
    inflight_cnt = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(wb_valid && (cnt_q == '0)))
        else $error("id_scoreboard: writeback with no op in flight");
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard with IW=2, four in-flight slots.
module tb_id_scoreboard;

  localparam int AW = 5;
  localparam int IW = 2;
  localparam int CW = 3;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            stall;
  logic [IW-1:0]   id_valid, id_long, id_rf_we, id_rs1_re, id_rs2_re;
  logic [AW*IW-1:0] id_rf_waddr, id_rs1_addr, id_rs2_addr;
  logic            wb_valid;
  logic [AW-1:0]   wb_addr;
  logic [IW-1:0]   hzd;
  logic            sb_stall;
  logic [CW-1:0]   inflight_cnt;

  int n_chk;
  int n_fail;

  id_scoreboard #(
    .CONFIG_P_ISSUE_WIDTH   (1),
    .CONFIG_SB_MAX_INFLIGHT (4),
    .CONFIG_SB_P_CNT        (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .stall        (stall),
    .id_valid     (id_valid),
    .id_long      (id_long),
    .id_rf_we     (id_rf_we),
    .id_rf_waddr  (id_rf_waddr),
    .id_rs1_re    (id_rs1_re),
    .id_rs2_re    (id_rs2_re),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .hzd          (hzd),
    .sb_stall     (sb_stall),
    .inflight_cnt (inflight_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flush       = 1'b0;
    stall       = 1'b0;
    id_valid    = '0;
    id_long     = '0;
    id_rf_we    = '0;
    id_rf_waddr = '0;
    id_rs1_re   = '0;
    id_rs2_re   = '0;
    id_rs1_addr = '0;
    id_rs2_addr = '0;
    wb_valid    = 1'b0;
    wb_addr     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lane 0 occupies the low AW bits of every packed address bus.
  task automatic issue(input logic [IW-1:0] lanes, input logic [AW-1:0] w1, input logic [AW-1:0] w0);
    id_valid    = lanes;
    id_long     = lanes;
    id_rf_we    = lanes;
    id_rf_waddr = {w1, w0};
  endtask

  task automatic wb(input logic [AW-1:0] a);
    wb_valid = 1'b1;
    wb_addr  = a;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_hzd",   32'(hzd), 32'h0);
    chk("rst_stall", 32'(sb_stall), 32'h0);
    chk("rst_cnt",   32'(inflight_cnt), 32'h0);
    rst = 1'b0;

    // Busy set, RAW hazard, writeback clears
    issue(2'b01, 5'd0, 5'd5);
    tick();
    idle_inputs();
    id_rs1_re   = 2'b01;
    id_rs1_addr = {5'd0, 5'd5};
    #1;
    chk("raw_hzd", 32'(hzd), 32'h1);
    chk("raw_cnt", 32'(inflight_cnt), 32'h1);
    wb(5'd5);
    #1;
    chk("no_bypass_hzd", 32'(hzd), 32'h1);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("wb_clr_hzd", 32'(hzd), 32'h0);
    chk("wb_clr_cnt", 32'(inflight_cnt), 32'h0);

    // In-window hazards
    idle_inputs();
    id_long     = 2'b01;
    id_rf_we    = 2'b01;
    id_rf_waddr = {5'd0, 5'd7};
    id_rs2_re   = 2'b10;
    id_rs2_addr = {5'd7, 5'd0};
    #1;
    chk("win_raw_hzd", 32'(hzd), 32'h2);
    id_rf_waddr = {5'd0, 5'd0};
    id_rs2_addr = {5'd0, 5'd0};
    #1;
    chk("win_x0_hzd", 32'(hzd), 32'h0);
    id_valid = 2'b01;
    tick();
    idle_inputs();
    #1;
    chk("x0_cnt", 32'(inflight_cnt), 32'h1);
    wb(5'd0);
    tick();
    idle_inputs();
    #1;
    chk("x0_wb_cnt", 32'(inflight_cnt), 32'h0);
    id_long     = 2'b01;
    id_rf_we    = 2'b11;
    id_rf_waddr = {5'd3, 5'd3};
    #1;
    chk("win_waw_hzd", 32'(hzd), 32'h2);
    idle_inputs();

    // Counter limit
    issue(2'b11, 5'd2, 5'd1);
    tick();
    idle_inputs();
    #1;
    chk("lim_cnt2",   32'(inflight_cnt), 32'h2);
    chk("lim_stall0", 32'(sb_stall), 32'h0);
    issue(2'b01, 5'd0, 5'd3);
    tick();
    idle_inputs();
    #1;
    chk("lim_cnt3",   32'(inflight_cnt), 32'h3);
    chk("lim_stall1", 32'(sb_stall), 32'h1);
    wb(5'd1);
    tick();
    idle_inputs();
    id_rs1_re   = 2'b10;
    id_rs1_addr = {5'd2, 5'd0};
    #1;
    chk("lim_wb_cnt",   32'(inflight_cnt), 32'h2);
    chk("lim_wb_stall", 32'(sb_stall), 32'h0);
    chk("lim_lane1_hzd", 32'(hzd), 32'h2);
    idle_inputs();

    // Flush drain
    flush = 1'b1;
    tick();
    idle_inputs();
    #1;
    chk("drn_stall", 32'(sb_stall), 32'h1);
    chk("drn_cnt",   32'(inflight_cnt), 32'h2);
    issue(2'b11, 5'd11, 5'd10);
    tick();
    idle_inputs();
    id_rs1_re   = 2'b01;
    id_rs1_addr = {5'd0, 5'd10};
    #1;
    chk("drn_ign_cnt", 32'(inflight_cnt), 32'h2);
    chk("drn_ign_hzd", 32'(hzd), 32'h0);
    idle_inputs();
    wb(5'd2);
    tick();
    idle_inputs();
    #1;
    chk("drn_wb1_cnt",   32'(inflight_cnt), 32'h1);
    chk("drn_wb1_stall", 32'(sb_stall), 32'h1);
    wb(5'd3);
    tick();
    idle_inputs();
    #1;
    chk("drn_done_cnt",   32'(inflight_cnt), 32'h0);
    chk("drn_done_stall", 32'(sb_stall), 32'h0);

    // Backend stall blocks acceptance
    stall = 1'b1;
    issue(2'b01, 5'd0, 5'd9);
    tick();
    #1;
    chk("bstall_cnt", 32'(inflight_cnt), 32'h0);
    stall = 1'b0;
    tick();
    #1;
    chk("iss9_cnt", 32'(inflight_cnt), 32'h1);

    // Same-register writeback and reissue: set wins, count unchanged
    wb(5'd9);
    tick();
    idle_inputs();
    id_rs1_re   = 2'b01;
    id_rs1_addr = {5'd0, 5'd9};
    #1;
    chk("same_cnt", 32'(inflight_cnt), 32'h1);
    chk("same_hzd", 32'(hzd), 32'h1);
    wb(5'd9);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("same_clr_cnt", 32'(inflight_cnt), 32'h0);
    chk("same_clr_hzd", 32'(hzd), 32'h0);
    idle_inputs();

    // Reset in the middle of a drain
    issue(2'b11, 5'd13, 5'd12);
    tick();
    issue(2'b01, 5'd0, 5'd14);
    tick();
    idle_inputs();
    flush = 1'b1;
    tick();
    idle_inputs();
    #1;
    chk("pre_rst_cnt",   32'(inflight_cnt), 32'h3);
    chk("pre_rst_stall", 32'(sb_stall), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    id_rs1_re   = 2'b01;
    id_rs1_addr = {5'd0, 5'd12};
    id_rs2_re   = 2'b10;
    id_rs2_addr = {5'd14, 5'd0};
    #1;
    chk("mid_rst_cnt",   32'(inflight_cnt), 32'h0);
    chk("mid_rst_stall", 32'(sb_stall), 32'h0);
    chk("mid_rst_hzd",   32'(hzd), 32'h0);
    idle_inputs();
    issue(2'b01, 5'd0, 5'd4);
    tick();
    idle_inputs();
    #1;
    chk("post_rst_iss_cnt", 32'(inflight_cnt), 32'h1);
    wb(5'd4);
    tick();
    idle_inputs();
    #1;
    chk("post_rst_wb_cnt", 32'(inflight_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
